// File: rtl/cdb_writeback_pkg.sv
// Shared writeback types: the result-bus entry format, FU selector and ROB age compare.
package cdb_writeback_pkg;

    localparam int ROB_TAG_W = 5;
    localparam int PREG_W    = 7;
    localparam int DATA_W    = 32;
    localparam int NUM_FU    = 3;

    typedef struct packed {
        logic                 valid;
        logic [ROB_TAG_W-1:0] rob_tag;
        logic [PREG_W-1:0]    pd;
        logic [DATA_W-1:0]    data;
        logic                 we;
        logic                 mispredict;
    } wb_entry;

    typedef enum logic [1:0] {
        FuAlu = 2'd0,
        FuB   = 2'd1,
        FuMem = 2'd2
    } fu_sel_e;

    function automatic fu_sel_e next_fu(input fu_sel_e fu);
        fu_sel_e nxt;
        unique case (fu)
            FuAlu:   nxt = FuB;
            FuB:     nxt = FuMem;
            default: nxt = FuAlu;
        endcase
        return nxt;
    endfunction

    // Ages are distances from the ROB head, so wrap-around of tags is handled.
    function automatic logic is_younger(input logic [ROB_TAG_W-1:0] tag,
                                        input logic [ROB_TAG_W-1:0] branch_tag,
                                        input logic [ROB_TAG_W-1:0] head);
        logic [ROB_TAG_W-1:0] age_tag;
        logic [ROB_TAG_W-1:0] age_branch;
        age_tag    = tag - head;
        age_branch = branch_tag - head;
        return age_tag > age_branch;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-FU result queue with empty-queue bypass and same-cycle flush of entries younger
// than a mispredicting branch; survivors are compacted so the count tracks live entries.
module wb_fifo
    import cdb_writeback_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  wb_entry              push_entry,
    input  logic                 pop,
    input  logic                 flush,
    input  logic [ROB_TAG_W-1:0] flush_tag,
    input  logic [ROB_TAG_W-1:0] rob_head,
    output logic                 ready,
    output logic                 head_valid,
    output wb_entry              head_entry
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    wb_entry mem_q [DEPTH];
    wb_entry mem_d [DEPTH];
    ptr_t    rd_q;
    ptr_t    rd_d;
    cnt_t    cnt_q;
    cnt_t    cnt_d;

    logic    empty;
    logic    push_live;
    ptr_t    base;
    cnt_t    kept;

    assign empty     = (cnt_q == '0);
    assign ready     = (cnt_q != cnt_t'(DEPTH));
    assign push_live = push && ready &&
                       !(flush && is_younger(push_entry.rob_tag, flush_tag, rob_head));

    // An empty queue presents the incoming result directly so it can win this cycle.
    always_comb begin
        if (empty) begin
            head_entry = push_entry;
            head_valid = push_live;
        end else begin
            head_entry = mem_q[rd_q];
            head_valid = !(flush && is_younger(mem_q[rd_q].rob_tag, flush_tag, rob_head));
        end
    end

    always_comb begin
        mem_d = mem_q;
        base  = (pop && !empty) ? ptr_t'(rd_q + ptr_t'(1)) : rd_q;
        kept  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((cnt_t'(i) < cnt_q) && !(pop && (i == 0)) &&
                !(flush && is_younger(mem_q[ptr_t'(rd_q + ptr_t'(i))].rob_tag,
                                      flush_tag, rob_head))) begin
                mem_d[ptr_t'(base + ptr_t'(kept))] = mem_q[ptr_t'(rd_q + ptr_t'(i))];
                kept = kept + cnt_t'(1);
            end
        end
        // A bypassed result that is granted this cycle never occupies a slot.
        if (push_live && !(pop && empty)) begin
            mem_d[ptr_t'(base + ptr_t'(kept))] = push_entry;
            kept = kept + cnt_t'(1);
        end
        rd_d  = base;
        cnt_d = kept;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/cdb_writeback.sv
// Common data bus writeback: three FU result queues, round-robin arbitration and a single
// registered broadcast to ROB, PRF and reservation stations.
module cdb_writeback
    import cdb_writeback_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 alu_valid,
    input  logic [ROB_TAG_W-1:0] alu_rob_tag,
    input  logic [PREG_W-1:0]    alu_pd,
    input  logic [DATA_W-1:0]    alu_data,
    input  logic                 alu_we,
    output logic                 alu_ready,

    input  logic                 b_valid,
    input  logic [ROB_TAG_W-1:0] b_rob_tag,
    input  logic [PREG_W-1:0]    b_pd,
    input  logic [DATA_W-1:0]    b_data,
    input  logic                 b_we,
    input  logic                 b_mispredict,
    output logic                 b_ready,

    input  logic                 mem_valid,
    input  logic [ROB_TAG_W-1:0] mem_rob_tag,
    input  logic [PREG_W-1:0]    mem_pd,
    input  logic [DATA_W-1:0]    mem_data,
    input  logic                 mem_we,
    output logic                 mem_ready,

    input  logic [ROB_TAG_W-1:0] rob_head,
    input  logic                 mispredict,
    input  logic [ROB_TAG_W-1:0] mispredict_tag,

    output logic                 cdb_valid,
    output logic [ROB_TAG_W-1:0] cdb_rob_tag,
    output logic [PREG_W-1:0]    cdb_pd,
    output logic [DATA_W-1:0]    cdb_data,
    output logic                 cdb_we,
    output logic                 cdb_mispredict
);

    wb_entry                alu_entry;
    wb_entry                b_entry;
    wb_entry                mem_entry;
    wb_entry [NUM_FU-1:0]   heads;
    logic    [NUM_FU-1:0]   head_valid;
    logic    [NUM_FU-1:0]   pop;

    fu_sel_e prio_q;
    fu_sel_e sel;
    fu_sel_e grant_sel;
    logic    any_grant;

    // Only branch results can carry a mispredict flag onto the bus.
    always_comb begin
        alu_entry = '{valid: 1'b1, rob_tag: alu_rob_tag, pd: alu_pd, data: alu_data,
                      we: alu_we, mispredict: 1'b0};
        b_entry   = '{valid: 1'b1, rob_tag: b_rob_tag, pd: b_pd, data: b_data,
                      we: b_we, mispredict: b_mispredict};
        mem_entry = '{valid: 1'b1, rob_tag: mem_rob_tag, pd: mem_pd, data: mem_data,
                      we: mem_we, mispredict: 1'b0};
    end

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_alu_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (alu_valid),
        .push_entry (alu_entry),
        .pop        (pop[FuAlu]),
        .flush      (mispredict),
        .flush_tag  (mispredict_tag),
        .rob_head   (rob_head),
        .ready      (alu_ready),
        .head_valid (head_valid[FuAlu]),
        .head_entry (heads[FuAlu])
    );

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_b_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (b_valid),
        .push_entry (b_entry),
        .pop        (pop[FuB]),
        .flush      (mispredict),
        .flush_tag  (mispredict_tag),
        .rob_head   (rob_head),
        .ready      (b_ready),
        .head_valid (head_valid[FuB]),
        .head_entry (heads[FuB])
    );

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_mem_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (mem_valid),
        .push_entry (mem_entry),
        .pop        (pop[FuMem]),
        .flush      (mispredict),
        .flush_tag  (mispredict_tag),
        .rob_head   (rob_head),
        .ready      (mem_ready),
        .head_valid (head_valid[FuMem]),
        .head_entry (heads[FuMem])
    );

    // Search starts at the priority pointer and takes the first live head.
    always_comb begin
        sel       = prio_q;
        grant_sel = prio_q;
        any_grant = 1'b0;
        for (int k = 0; k < NUM_FU; k++) begin
            if (!any_grant && head_valid[sel]) begin
                any_grant = 1'b1;
                grant_sel = sel;
            end
            sel = next_fu(sel);
        end
    end

    always_comb begin
        pop            = '0;
        pop[grant_sel] = any_grant;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q         <= FuAlu;
            cdb_valid      <= 1'b0;
            cdb_rob_tag    <= '0;
            cdb_pd         <= '0;
            cdb_data       <= '0;
            cdb_we         <= 1'b0;
            cdb_mispredict <= 1'b0;
        end else begin
            cdb_valid <= any_grant && heads[grant_sel].valid;
            if (any_grant) begin
                prio_q         <= next_fu(grant_sel);
                cdb_rob_tag    <= heads[grant_sel].rob_tag;
                cdb_pd         <= heads[grant_sel].pd;
                cdb_data       <= heads[grant_sel].data;
                cdb_we         <= heads[grant_sel].we;
                cdb_mispredict <= heads[grant_sel].mispredict;
            end
        end
    end

endmodule

// File: tb/tb_cdb_writeback.sv
// Directed bench for cdb_writeback: arbitration order, back-pressure, flush and reset.
module tb_cdb_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, b_valid, mem_valid;
    logic [4:0]  alu_rob_tag, b_rob_tag, mem_rob_tag;
    logic [6:0]  alu_pd, b_pd, mem_pd;
    logic [31:0] alu_data, b_data, mem_data;
    logic        alu_we, b_we, mem_we, b_mispredict;
    logic        alu_ready, b_ready, mem_ready;
    logic [4:0]  rob_head, mispredict_tag;
    logic        mispredict;
    logic        cdb_valid, cdb_we, cdb_mispredict;
    logic [4:0]  cdb_rob_tag;
    logic [6:0]  cdb_pd;
    logic [31:0] cdb_data;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [4:0] tag;
        logic [6:0] pd;
        logic       mp;
    } bc_t;
    bc_t bc_log[$];

    cdb_writeback #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rob_tag(alu_rob_tag), .alu_pd(alu_pd),
        .alu_data(alu_data), .alu_we(alu_we), .alu_ready(alu_ready),
        .b_valid(b_valid), .b_rob_tag(b_rob_tag), .b_pd(b_pd), .b_data(b_data),
        .b_we(b_we), .b_mispredict(b_mispredict), .b_ready(b_ready),
        .mem_valid(mem_valid), .mem_rob_tag(mem_rob_tag), .mem_pd(mem_pd),
        .mem_data(mem_data), .mem_we(mem_we), .mem_ready(mem_ready),
        .rob_head(rob_head), .mispredict(mispredict), .mispredict_tag(mispredict_tag),
        .cdb_valid(cdb_valid), .cdb_rob_tag(cdb_rob_tag), .cdb_pd(cdb_pd),
        .cdb_data(cdb_data), .cdb_we(cdb_we), .cdb_mispredict(cdb_mispredict)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cdb_valid === 1'b1) bc_log.push_back('{tag: cdb_rob_tag, pd: cdb_pd, mp: cdb_mispredict});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 0; b_valid = 0; mem_valid = 0;
        alu_rob_tag = 0; b_rob_tag = 0; mem_rob_tag = 0;
        alu_pd = 0; b_pd = 0; mem_pd = 0;
        alu_data = 0; b_data = 0; mem_data = 0;
        alu_we = 0; b_we = 0; mem_we = 0; b_mispredict = 0;
        mispredict = 0; mispredict_tag = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        step();
        step();
        reset = 0;
        rob_head = 0;
        idle();
    endtask

    task automatic drive_alu(input logic [4:0] tag, input logic [6:0] pd, input logic [31:0] d);
        alu_valid = 1; alu_rob_tag = tag; alu_pd = pd; alu_data = d; alu_we = 1;
    endtask

    task automatic drive_b(input logic [4:0] tag, input logic [6:0] pd, input logic mp);
        b_valid = 1; b_rob_tag = tag; b_pd = pd; b_data = 32'h0B00_0000 | 32'(pd);
        b_we = 0; b_mispredict = mp;
    endtask

    task automatic drive_mem(input logic [4:0] tag, input logic [6:0] pd);
        mem_valid = 1; mem_rob_tag = tag; mem_pd = pd; mem_data = 32'h0E00_0000 | 32'(pd);
        mem_we = 1;
    endtask

    task automatic test_reset();
        idle();
        drive_alu(5'd9, 7'd9, 32'h1234);  // offered while reset is held
        reset = 1;
        step();
        step();
        reset = 0;
        idle();
        checks++; if (cdb_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", cdb_valid); else passes++;
        checks++; if (cdb_rob_tag !== 5'd0) $display("FAIL reset_tag: got %0d want 0", cdb_rob_tag); else passes++;
        checks++; if (cdb_pd !== 7'd0) $display("FAIL reset_pd: got %0d want 0", cdb_pd); else passes++;
        checks++; if (cdb_data !== 32'd0) $display("FAIL reset_data: got %h want 0", cdb_data); else passes++;
        checks++; if (cdb_we !== 1'b0 || cdb_mispredict !== 1'b0)
            $display("FAIL reset_we_mp: got %b%b want 00", cdb_we, cdb_mispredict); else passes++;
        checks++; if ({alu_ready, b_ready, mem_ready} !== 3'b111)
            $display("FAIL reset_ready: got %b want 111", {alu_ready, b_ready, mem_ready}); else passes++;
        step();
        checks++; if (cdb_valid !== 1'b0) $display("FAIL reset_no_bcast: got %b want 0", cdb_valid); else passes++;
    endtask

    task automatic test_single();
        do_reset();
        drive_alu(5'd3, 7'd10, 32'hDEADBEEF);
        step();
        idle();
        b_pd = 7'h7F; b_data = 32'hFFFF_FFFF; b_we = 1;  // junk with b_valid low
        checks++; if (cdb_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", cdb_valid); else passes++;
        checks++; if (cdb_rob_tag !== 5'd3) $display("FAIL single_tag: got %0d want 3", cdb_rob_tag); else passes++;
        checks++; if (cdb_pd !== 7'd10) $display("FAIL single_pd: got %0d want 10", cdb_pd); else passes++;
        checks++; if (cdb_data !== 32'hDEADBEEF) $display("FAIL single_data: got %h want deadbeef", cdb_data); else passes++;
        checks++; if (cdb_we !== 1'b1 || cdb_mispredict !== 1'b0)
            $display("FAIL single_we_mp: got %b%b want 10", cdb_we, cdb_mispredict); else passes++;
        step();
        checks++; if (cdb_valid !== 1'b0) $display("FAIL single_once: got %b want 0", cdb_valid); else passes++;
        checks++; if (cdb_data !== 32'hDEADBEEF || cdb_rob_tag !== 5'd3)
            $display("FAIL single_hold: got %h/%0d want deadbeef/3", cdb_data, cdb_rob_tag); else passes++;
        idle();
    endtask

    task automatic test_round_robin();
        do_reset();
        drive_alu(5'd1, 7'd1, 32'h11);
        drive_b(5'd2, 7'd2, 1'b0);
        drive_mem(5'd4, 7'd4);
        step();
        idle();
        checks++; if (cdb_valid !== 1'b1 || cdb_rob_tag !== 5'd1)
            $display("FAIL rr_first: got v%b tag %0d want v1 tag 1", cdb_valid, cdb_rob_tag); else passes++;
        step();
        checks++; if (cdb_valid !== 1'b1 || cdb_rob_tag !== 5'd2)
            $display("FAIL rr_second: got v%b tag %0d want v1 tag 2", cdb_valid, cdb_rob_tag); else passes++;
        step();
        checks++; if (cdb_valid !== 1'b1 || cdb_rob_tag !== 5'd4)
            $display("FAIL rr_third: got v%b tag %0d want v1 tag 4", cdb_valid, cdb_rob_tag); else passes++;
        // Pointer is back on alu, so alu wins a tie with b.
        drive_alu(5'd6, 7'd6, 32'h66);
        drive_b(5'd7, 7'd7, 1'b0);
        step();
        idle();
        checks++; if (cdb_valid !== 1'b1 || cdb_rob_tag !== 5'd6)
            $display("FAIL rr_wrap_alu: got v%b tag %0d want v1 tag 6", cdb_valid, cdb_rob_tag); else passes++;
        step();
        checks++; if (cdb_valid !== 1'b1 || cdb_rob_tag !== 5'd7)
            $display("FAIL rr_wrap_b: got v%b tag %0d want v1 tag 7", cdb_valid, cdb_rob_tag); else passes++;
        step();
        checks++; if (cdb_valid !== 1'b0) $display("FAIL rr_drained: got %b want 0", cdb_valid); else passes++;
    endtask

    task automatic test_fill();
        logic [5:0] exp_ready;
        int         n_mem;
        exp_ready = 6'b011111;  // bit c: mem_ready expected in cycle c
        do_reset();
        bc_log.delete();
        for (int c = 0; c < 6; c++) begin
            idle();
            if (c < 5) begin
                drive_alu(5'(c), 7'(8'h10 + c), 32'(c));
                drive_b(5'(8 + c), 7'(8'h20 + c), 1'b0);
            end
            drive_mem(5'(16 + c), 7'(8'h40 + c));
            checks++; if (mem_ready !== exp_ready[c])
                $display("FAIL fill_ready_c%0d: got %b want %b", c, mem_ready, exp_ready[c]); else passes++;
            step();
        end
        idle();
        repeat (25) step();
        checks++; if (bc_log.size() != 15)
            $display("FAIL fill_total: got %0d broadcasts want 15", bc_log.size()); else passes++;
        n_mem = 0;
        foreach (bc_log[i]) begin
            if (bc_log[i].pd[6:4] == 3'h4) begin
                checks++; if (bc_log[i].pd !== 7'(8'h40 + n_mem))
                    $display("FAIL fill_mem_order%0d: got pd %h want %h", n_mem, bc_log[i].pd, 8'h40 + n_mem);
                else passes++;
                n_mem++;
            end
        end
        checks++; if (n_mem != 5) $display("FAIL fill_mem_count: got %0d want 5", n_mem); else passes++;
    endtask

    task automatic test_flush();
        int bad;
        do_reset();
        rob_head = 5'd30;
        bc_log.delete();
        drive_alu(5'd31, 7'd31, 32'h31);
        drive_b(5'd1, 7'd1, 1'b0);
        drive_mem(5'd2, 7'd2);
        step();
        idle();
        checks++; if (cdb_valid !== 1'b1 || cdb_rob_tag !== 5'd31)
            $display("FAIL flush_tag31: got v%b tag %0d want v1 tag 31", cdb_valid, cdb_rob_tag); else passes++;
        mispredict = 1; mispredict_tag = 5'd1;
        drive_alu(5'd0, 7'd0, 32'h0);  // older than the branch, must survive
        step();
        idle();
        mispredict = 1; mispredict_tag = 5'd1;
        drive_b(5'd5, 7'd5, 1'b0);  // younger, dropped on arrival
        checks++; if (cdb_valid !== 1'b1 || cdb_rob_tag !== 5'd1)
            $display("FAIL flush_branch_kept: got v%b tag %0d want v1 tag 1", cdb_valid, cdb_rob_tag); else passes++;
        step();
        idle();
        checks++; if (cdb_valid !== 1'b1 || cdb_rob_tag !== 5'd0)
            $display("FAIL flush_older_kept: got v%b tag %0d want v1 tag 0", cdb_valid, cdb_rob_tag); else passes++;
        repeat (6) step();
        checks++; if (bc_log.size() != 3)
            $display("FAIL flush_count: got %0d broadcasts want 3", bc_log.size()); else passes++;
        bad = 0;
        foreach (bc_log[i]) if (bc_log[i].tag == 5'd2 || bc_log[i].tag == 5'd5) bad++;
        checks++; if (bad != 0) $display("FAIL flush_younger_seen: got %0d want 0", bad); else passes++;
        checks++; if ({b_ready, mem_ready} !== 2'b11)
            $display("FAIL flush_ready: got %b want 11", {b_ready, mem_ready}); else passes++;
    endtask

    task automatic test_branch_mp();
        do_reset();
        drive_b(5'd5, 7'd5, 1'b1);
        step();
        idle();
        checks++; if (cdb_valid !== 1'b1 || cdb_rob_tag !== 5'd5 || cdb_mispredict !== 1'b1)
            $display("FAIL bmp_set: got v%b tag %0d mp %b want v1 tag 5 mp 1",
                     cdb_valid, cdb_rob_tag, cdb_mispredict); else passes++;
        drive_alu(5'd6, 7'd6, 32'h6);
        step();
        idle();
        checks++; if (cdb_valid !== 1'b1 || cdb_rob_tag !== 5'd6 || cdb_mispredict !== 1'b0)
            $display("FAIL bmp_clear: got v%b tag %0d mp %b want v1 tag 6 mp 0",
                     cdb_valid, cdb_rob_tag, cdb_mispredict); else passes++;
    endtask

    task automatic test_reset_flush();
        do_reset();
        drive_alu(5'd1, 7'd1, 32'h1); drive_b(5'd2, 7'd2, 1'b0); drive_mem(5'd3, 7'd3);
        step();
        drive_alu(5'd4, 7'd4, 32'h4); drive_b(5'd5, 7'd5, 1'b0); drive_mem(5'd6, 7'd6);
        step();
        idle();
        drive_alu(5'd7, 7'd7, 32'h7);
        mispredict = 1; mispredict_tag = 5'd3;
        reset = 1;
        step();
        reset = 0;
        idle();
        checks++; if (cdb_valid !== 1'b0 || cdb_rob_tag !== 5'd0)
            $display("FAIL rst_mid_cdb: got v%b tag %0d want v0 tag 0", cdb_valid, cdb_rob_tag); else passes++;
        checks++; if ({alu_ready, b_ready, mem_ready} !== 3'b111)
            $display("FAIL rst_mid_ready: got %b want 111", {alu_ready, b_ready, mem_ready}); else passes++;
        bc_log.delete();
        repeat (6) step();
        checks++; if (bc_log.size() != 0)
            $display("FAIL rst_mid_stale: got %0d broadcasts want 0", bc_log.size()); else passes++;
    endtask

    initial begin
        reset = 1;
        rob_head = 0;
        idle();
        test_reset();
        test_single();
        test_round_robin();
        test_fill();
        test_flush();
        test_branch_mp();
        test_reset_flush();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/cdb_writeback.md
CDB_WRITEBACK -- requirements
Module: cdb_writeback

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, entries per FU queue (power of two, >=2).
REQ-002 SHALL have ports clk (input, 1, clock) and reset (input, 1, synchronous active-high reset); one clock, reset synchronous and active-high.
REQ-003 SHALL have, for each X in {alu, b, mem}, ports X_valid (input, 1, result present), X_rob_tag (input, 5, ROB index), X_pd (input, 7, dest phys reg), X_data (input, 32, result), X_we (input, 1, writes PRF).
REQ-004 SHALL have b_mispredict (input, 1, branch result mispredicted) and X_ready (output, 1, queue X accepts this cycle) for each FU.
REQ-005 SHALL have rob_head (input, 5), mispredict (input, 1, flush request), mispredict_tag (input, 5, ROB tag of mispredicting branch).
REQ-006 SHALL have outputs cdb_valid (1), cdb_rob_tag (5), cdb_pd (7), cdb_data (32), cdb_we (1), cdb_mispredict (1): one registered broadcast to ROB, PRF, RS.

Function
REQ-007 SHALL enqueue X's result when X_valid && X_ready; X_ready = queue X not full, computed from pre-cycle occupancy (no same-cycle dequeue bypass).
REQ-008 SHALL keep each queue in FIFO order; pointers wrap mod FIFO_DEPTH; count 0..FIFO_DEPTH.
REQ-009 SHALL select at most one non-empty queue head per cycle by round-robin over order alu, b, mem; priority pointer moves to the FU after the granted one; unchanged when no grant.
REQ-010 SHALL register the granted head onto cdb_* with cdb_valid=1 next cycle, then pop it; minimum enqueue-to-broadcast latency 1 cycle.
REQ-011 SHALL drive cdb_valid=0 in any cycle following no grant; other cdb_* fields hold last value.
REQ-012 SHALL define age(t) = (t - rob_head) mod 32; entry is younger than branch when age(tag) > age(mispredict_tag).
REQ-013 SHALL, when mispredict=1, invalidate every queued entry younger than mispredict_tag and drop incoming X_valid results younger than it, same cycle.
REQ-014 SHALL not flush the entry whose tag equals mispredict_tag, nor any older entry.
REQ-015 SHALL exclude younger entries from arbitration in the mispredict cycle, so no younger result reaches cdb_* afterward.
REQ-016 SHALL compact or skip invalidated entries so queue counts reflect only live entries by the cycle after mispredict.
REQ-017 SHALL set cdb_mispredict only for results sourced from the b queue carrying b_mispredict=1; 0 otherwise.
REQ-018 SHALL ignore X_pd/X_data/X_we contents when X_valid=0.
REQ-019 SHALL, with all three queues full and none granted, hold all X_ready=0 without losing or duplicating entries.

Reset
REQ-020 SHALL on reset clear all queue pointers and counts, set priority pointer to alu, drive cdb_valid=0, cdb_mispredict=0, cdb_rob_tag=0, cdb_pd=0, cdb_data=0, cdb_we=0.
REQ-021 SHALL drive every X_ready=1 in the first cycle after reset deasserts.
REQ-022 SHALL give reset priority over concurrent enqueue, grant, and mispredict; in-flight entries discarded.

Structure
REQ-023 SHALL declare typedef wb_entry (valid, rob_tag, pd, data, we, mispredict) and constant ROB_TAG_W=5 in the shared type package used by RS/FU blocks.
REQ-024 SHALL instantiate three copies of sub-module wb_fifo (parameterized depth, tag-based flush port); arbitration and output register live in cdb_writeback.

Verification
REQ-025 Single ALU result: alu_valid, tag 3, pd 10, data 0xDEADBEEF, we=1 at cycle N -> cdb_valid, tag 3, pd 10, data 0xDEADBEEF at N+1 only.
REQ-026 Simultaneous valid on alu(tag 1), b(tag 2), mem(tag 4) at N, pointer=alu -> broadcast tags 1,2,4 at N+1,N+2,N+3; pointer back to alu.
REQ-027 Fill mem queue with 4 entries while alu busy -> mem_ready=0 after 4th; 5th offer not accepted; all 4 broadcast in order later.
REQ-028 rob_head=30, queued tags 31,1,2, mispredict_tag=1 -> tag 2 flushed; 31 and 1 broadcast; tag 2 never appears.
REQ-029 Branch tag 5 with b_mispredict=1 -> cdb_mispredict=1 with tag 5; ALU result after it -> cdb_mispredict=0.
REQ-030 Reset asserted with 3 entries queued -> cdb_valid=0 next cycle, all X_ready=1 after deassert, no stale broadcast.
